gesture_power_controller: RTL and testbench

- Power-state sequencer for the hood. It owns power_status, which feeds the reminder/gesture time-setting block and the downstream mode logic.
- Power is controlled two ways:
  - Button: a short press turns the hood on; a long press turns it off.
  - Two-sensor gesture: left then right within gesture_time turns it on; right then left within gesture_time turns it off.
- gesture_time comes from the time-setting block, in clk cycles.

---
 rtl/gesture_power_controller.sv | 119 +++++++++++
 tb/tb_gesture_power_controller.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/gesture_power_controller.sv
// Hood power-state sequencer: button short/long press and two-sensor swipe gestures
// drive OFF / ARM_ON / ON / ARM_OFF, with registered status, arm state and pulses.
module gesture_power_controller #(
    parameter int unsigned LONG_PRESS = 300_000_000,
    parameter int unsigned GT_W       = 30
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            power_button,
    input  logic            left_sensor,
    input  logic            right_sensor,
    input  logic [GT_W-1:0] gesture_time,
    output logic            power_status,
    output logic            power_on_pulse,
    output logic            power_off_pulse,
    output logic [1:0]      arm_state
);

    localparam int unsigned LP_W = $clog2(LONG_PRESS) + 1;
    localparam logic [LP_W-1:0] LP_LAST = LP_W'(LONG_PRESS - 1);

    typedef enum logic [1:0] {OFF, ARM_ON, ON, ARM_OFF} state_t;

    state_t          state, state_nx;
    logic [GT_W-1:0] timer, timer_nx;
    logic [LP_W-1:0] press_cnt, press_cnt_nx;
    logic            button_prev, left_prev, right_prev;
    logic            button_rise, left_rise, right_rise;
    logic            left_only, right_only;
    logic            gt_nonzero, powered, long_press;
    logic            status_nx, on_pulse_nx, off_pulse_nx;
    logic [1:0]      arm_nx;

    assign button_rise = power_button & ~button_prev;
    assign left_rise   = left_sensor & ~left_prev;
    assign right_rise  = right_sensor & ~right_prev;
    assign left_only   = left_rise & ~right_rise;
    assign right_only  = right_rise & ~left_rise;
    assign gt_nonzero  = (gesture_time != '0);
    assign powered     = (state == ON) || (state == ARM_OFF);
    assign long_press  = powered && power_button && (press_cnt == LP_LAST);

    always_comb begin
        state_nx = state;
        timer_nx = timer;
        unique case (state)
            OFF: begin
                if (button_rise) begin
                    state_nx = ON;
                end else if (left_only && gt_nonzero) begin
                    state_nx = ARM_ON;
                    timer_nx = gesture_time - 1'b1;
                end
            end
            ARM_ON: begin
                // Matching edge wins over the timeout in the timer==0 cycle.
                if (button_rise || right_only) begin
                    state_nx = ON;
                end else if (timer == '0) begin
                    state_nx = OFF;
                end else begin
                    timer_nx = timer - 1'b1;
                end
            end
            ON: begin
                if (long_press) begin
                    state_nx = OFF;
                end else if (right_only && gt_nonzero) begin
                    state_nx = ARM_OFF;
                    timer_nx = gesture_time - 1'b1;
                end
            end
            ARM_OFF: begin
                if (long_press || left_only) begin
                    state_nx = OFF;
                end else if (timer == '0) begin
                    state_nx = ON;
                end else begin
                    timer_nx = timer - 1'b1;
                end
            end
            default: state_nx = OFF;
        endcase

        press_cnt_nx = (powered && power_button && !long_press) ? press_cnt + 1'b1 : '0;

        status_nx    = (state_nx == ON) || (state_nx == ARM_OFF);
        on_pulse_nx  = (state_nx == ON) && ((state == OFF) || (state == ARM_ON));
        off_pulse_nx = (state_nx == OFF) && powered;
        arm_nx       = {state_nx == ARM_OFF, state_nx == ARM_ON};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= OFF;
            timer           <= '0;
            press_cnt       <= '0;
            button_prev     <= 1'b0;
            left_prev       <= 1'b0;
            right_prev      <= 1'b0;
            power_status    <= 1'b0;
            power_on_pulse  <= 1'b0;
            power_off_pulse <= 1'b0;
            arm_state       <= '0;
        end else begin
            state           <= state_nx;
            timer           <= timer_nx;
            press_cnt       <= press_cnt_nx;
            button_prev     <= power_button;
            left_prev       <= left_sensor;
            right_prev      <= right_sensor;
            power_status    <= status_nx;
            power_on_pulse  <= on_pulse_nx;
            power_off_pulse <= off_pulse_nx;
            arm_state       <= arm_nx;
        end
    end

endmodule

// File: tb/tb_gesture_power_controller.sv
// Directed plus randomized bench for gesture_power_controller against a
// deadline/hold-time reference model of the power sequencing rules.
module tb_gesture_power_controller;

    localparam int unsigned LP  = 10;
    localparam int unsigned GTW = 30;
    localparam int M_OFF = 0, M_ARM_ON = 1, M_ON = 2, M_ARM_OFF = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           power_button = 1'b0;
    logic           left_sensor = 1'b0;
    logic           right_sensor = 1'b0;
    logic [GTW-1:0] gesture_time = 30'd20;
    logic           power_status, power_on_pulse, power_off_pulse;
    logic [1:0]     arm_state;

    int tests = 0;
    int fails = 0;

    // Reference model: mode plus absolute deadline cycle and hold-start cycle.
    int         m_mode, cyc, deadline, hold_start;
    bit         pb, pl, pr;
    logic       e_ps, e_on, e_off;
    logic [1:0] e_arm;

    gesture_power_controller #(.LONG_PRESS(LP), .GT_W(GTW)) dut (
        .clk(clk),
        .rst(rst),
        .power_button(power_button),
        .left_sensor(left_sensor),
        .right_sensor(right_sensor),
        .gesture_time(gesture_time),
        .power_status(power_status),
        .power_on_pulse(power_on_pulse),
        .power_off_pulse(power_off_pulse),
        .arm_state(arm_state)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_mode = M_OFF; cyc = 0; deadline = 0; hold_start = -1;
        pb = 0; pl = 0; pr = 0;
        e_ps = 0; e_on = 0; e_off = 0; e_arm = 2'b00;
    endtask

    task automatic model_edge(bit b, bit l, bit r);
        bit br, lr, rr, lo, ro, pw, long_p, gt_ok;
        int nxt;
        cyc++;
        br = b && !pb; lr = l && !pl; rr = r && !pr;
        lo = lr && !rr; ro = rr && !lr;
        pw = (m_mode == M_ON) || (m_mode == M_ARM_OFF);
        gt_ok = (gesture_time != 0);
        long_p = 0;
        if (pw && b) begin
            if (hold_start < 0) hold_start = cyc;
            long_p = ((cyc - hold_start + 1) == LP);
        end else begin
            hold_start = -1;
        end
        nxt = m_mode;
        case (m_mode)
            M_OFF: begin
                if (br) nxt = M_ON;
                else if (lo && gt_ok) begin nxt = M_ARM_ON; deadline = cyc + int'(gesture_time); end
            end
            M_ARM_ON: begin
                if (br || ro) nxt = M_ON;
                else if (cyc == deadline) nxt = M_OFF;
            end
            M_ON: begin
                if (long_p) nxt = M_OFF;
                else if (ro && gt_ok) begin nxt = M_ARM_OFF; deadline = cyc + int'(gesture_time); end
            end
            default: begin
                if (long_p || lo) nxt = M_OFF;
                else if (cyc == deadline) nxt = M_ON;
            end
        endcase
        e_on  = (nxt == M_ON) && (m_mode == M_OFF || m_mode == M_ARM_ON);
        e_off = (nxt == M_OFF) && pw;
        e_ps  = (nxt == M_ON) || (nxt == M_ARM_OFF);
        e_arm = (nxt == M_ARM_ON) ? 2'b01 : (nxt == M_ARM_OFF) ? 2'b10 : 2'b00;
        if (nxt == M_OFF || nxt == M_ARM_ON) hold_start = -1;
        m_mode = nxt;
        pb = b; pl = l; pr = r;
    endtask

    task automatic check_outputs();
        tests++;
        assert (power_status === e_ps) else begin
            fails++;
            $error("FAIL power_status cyc=%0d observed=%b expected=%b", cyc, power_status, e_ps);
        end
        tests++;
        assert (arm_state === e_arm) else begin
            fails++;
            $error("FAIL arm_state cyc=%0d observed=%b expected=%b", cyc, arm_state, e_arm);
        end
        tests++;
        assert (power_on_pulse === e_on) else begin
            fails++;
            $error("FAIL power_on_pulse cyc=%0d observed=%b expected=%b", cyc, power_on_pulse, e_on);
        end
        tests++;
        assert (power_off_pulse === e_off) else begin
            fails++;
            $error("FAIL power_off_pulse cyc=%0d observed=%b expected=%b", cyc, power_off_pulse, e_off);
        end
    endtask

    task automatic step(bit b, bit l, bit r);
        power_button = b; left_sensor = l; right_sensor = r;
        @(posedge clk);
        model_edge(b, l, r);
        #1;
        check_outputs();
    endtask

    task automatic idle(int n);
        repeat (n) step(0, 0, 0);
    endtask

    task automatic hold_button(int n);
        repeat (n) step(1, 0, 0);
        step(0, 0, 0);
    endtask

    initial begin
        bit rb, rl, rr;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_outputs();

        // Button short press powers on
        step(1, 0, 0);
        idle(2);
        // Long press: 9 cycles stays on, 10 powers off, 30 more stays off
        hold_button(9);
        idle(2);
        repeat (10) step(1, 0, 0);
        repeat (30) step(1, 0, 0);
        idle(2);

        // Left then right at +15 -> on; right then left at +5 -> off
        step(0, 1, 0); idle(14); step(0, 0, 1); idle(2);
        step(0, 0, 1); idle(4); step(0, 1, 0); idle(2);
        // Right at +20 still accepted
        step(0, 1, 0); idle(19); step(0, 0, 1); idle(2);
        // Right alone in ON: ARM_OFF for the window, then back to ON
        step(0, 0, 1); idle(25);
        hold_button(10);
        idle(2);
        // Right at +21 is too late
        step(0, 1, 0); idle(20); step(0, 0, 1); idle(3);

        // Simultaneous rises in OFF and in ON are ignored
        step(0, 1, 1); idle(3);
        step(1, 0, 0); idle(2);
        step(0, 1, 1); idle(3);
        hold_button(10);
        idle(2);
        // gesture_time == 0 disables arming
        gesture_time = '0;
        step(0, 1, 0); idle(3);
        gesture_time = 30'd20;
        idle(1);

        // Asynchronous reset mid-window
        step(0, 1, 0); idle(12);
        #3;
        rst = 1'b0;
        #1;
        tests++;
        assert ({power_status, power_on_pulse, power_off_pulse, arm_state} === 5'b0) else begin
            fails++;
            $error("FAIL async_reset observed=%b expected=%b",
                   {power_status, power_on_pulse, power_off_pulse, arm_state}, 5'b0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        step(0, 0, 1); idle(3);

        // Randomized phase
        rb = 0; rl = 0; rr = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 49) == 0)
                gesture_time = ($urandom_range(0, 3) == 0) ? 30'd20 : GTW'($urandom_range(0, 6));
            if ($urandom_range(0, 11) == 0) rb = !rb;
            if ($urandom_range(0, 3) == 0) rl = !rl;
            if ($urandom_range(0, 3) == 0) rr = !rr;
            step(rb, rl, rr);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
